pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/hazard_pkg.sv | 51 +++++
 rtl/load_use_detect.sv | 50 +++++
 rtl/pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   - hazard FSM state encoding (haz_state_e)
//   - MIPS opcode / COP0 sub-op field codes used for hazard detection
//   - pc_sel_exc select codes
//   - small decode helpers that take only the instruction fields they need
// ----------------------------------------------------------------------------
package hazard_pkg;

  // Hazard FSM states; the encoding is visible on haz_state
  typedef enum logic [1:0] {
    HS_RUN      = 2'b00,
    HS_LU_STALL = 2'b01,
    HS_MEM_WAIT = 2'b10,
    HS_FLUSH    = 2'b11
  } haz_state_e;

  // Every load (lb/lh/lwl/lw/lbu/lhu/lwr) has opcode 100xxx
  localparam logic [2:0] OP_LOAD_HI = 3'b100;

  // Coprocessor-0 opcode and its rs-field sub-operations
  localparam logic [5:0] OP_COP0  = 6'b010000;
  localparam logic [4:0] RS_MFC0  = 5'b00000;
  localparam logic [4:0] RS_MTC0  = 5'b00100;
  localparam logic [4:0] RS_ERET  = 5'b10000;
  localparam logic [5:0] FN_ERET  = 6'b011000;

  // Next-PC source selection
  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_EXC = 2'b01;
  localparam logic [1:0] PCSEL_EPC = 2'b10;

  function automatic logic is_load(input logic [2:0] op_hi);
    return op_hi == OP_LOAD_HI;
  endfunction

  function automatic logic is_mfc0(input logic [5:0] op, input logic [4:0] rs);
    return (op == OP_COP0) && (rs == RS_MFC0);
  endfunction

  function automatic logic is_mtc0(input logic [5:0] op, input logic [4:0] rs);
    return (op == OP_COP0) && (rs == RS_MTC0);
  endfunction

  function automatic logic is_eret(input logic [5:0] op, input logic [4:0] rs,
                                   input logic [5:0] funct);
    return (op == OP_COP0) && (rs == RS_ERET) && (funct == FN_ERET);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// ----------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use comparator: flags when the instruction in EX
// is a load whose destination (rt) is read as a source by the instruction in ID.
//
// Parameters:
//   ZERO_SKIP  1: a load targeting $0 never produces a hazard
// Ports:
//   instr_id   in  32  instruction in ID
//   instr_ex   in  32  instruction in EX
//   rfrd_id    in   2  ID sources actually read: bit0 = rs, bit1 = rt
//   load_use   out  1  load-use hazard present this cycle
// ----------------------------------------------------------------------------
module load_use_detect
  import hazard_pkg::*;
#(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic [31:0] instr_id,
  input  logic [31:0] instr_ex,
  input  logic [1:0]  rfrd_id,
  output logic        load_use
);

  logic [4:0] ex_rt;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       ex_is_load;
  logic       rs_hit;
  logic       rt_hit;
  logic       dest_ok;
  logic       unused_fields;

  assign ex_rt      = instr_ex[20:16];
  assign id_rs      = instr_id[25:21];
  assign id_rt      = instr_id[20:16];
  assign ex_is_load = is_load(instr_ex[31:29]);

  // Only sources that ID really reads can collide with the load result
  assign rs_hit = rfrd_id[0] && (id_rs == ex_rt);
  assign rt_hit = rfrd_id[1] && (id_rt == ex_rt);

  // $0 is hardwired to zero, so a load into it never feeds anything
  assign dest_ok = ZERO_SKIP ? (ex_rt != 5'd0) : 1'b1;

  assign load_use = ex_is_load && dest_ok && (rs_hit || rt_hit);

  assign unused_fields = ^{instr_id, instr_ex};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard / stall / flush controller for a 5-stage MIPS pipeline.
// Per-cycle priority: exception > ERET > memory wait > load-use > CP0 interlock
// > normal advance.
//
// Compile option:
//   HAZ_CP0_INTERLOCK_EN  when defined, an MFC0/ERET in ID stalls while an
//                         MTC0 sits in EX or MEM.
//
// Parameters:
//   LOAD_LAT   1..3  bubble cycles inserted per load-use hazard
//   ZERO_SKIP  1: a load into $0 never stalls
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   instr_id/instr_ex/instr_me    instructions in ID / EX / MEM
//   rfrd_id                       ID source regs read (00 none,01 rs,10 rt,11 both)
//   dm_req, dm_ack                MEM data-access valid / completes this cycle
//   exc_req, eret_me              exception taken at MEM / ERET at MEM
//   pc_wr..mewb_wr                stage register write enables
//   ifid_rst..mewb_rst            synchronous bubble/flush of stage registers
//   pc_sel_exc                    00 seq/branch, 01 exception vector, 10 EPC
//   haz_state                     current FSM state
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_LAT  = 1,
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_id,
  input  logic [31:0] instr_ex,
  input  logic [31:0] instr_me,
  input  logic [1:0]  rfrd_id,
  input  logic        dm_req,
  input  logic        dm_ack,
  input  logic        exc_req,
  input  logic        eret_me,
  output logic        pc_wr,
  output logic        ifid_wr,
  output logic        idex_wr,
  output logic        exme_wr,
  output logic        mewb_wr,
  output logic        ifid_rst,
  output logic        idex_rst,
  output logic        exme_rst,
  output logic        mewb_rst,
  output logic [1:0]  pc_sel_exc,
  output logic [1:0]  haz_state
);

  // Bubbles still owed after the first one, loaded when a hazard is detected
  localparam logic [1:0] LU_EXTRA = 2'(LOAD_LAT - 1);

  haz_state_e state;
  haz_state_e state_nxt;
  logic [1:0] lu_cnt;
  logic [1:0] cnt_nxt;
  logic       load_use;
  logic       mem_wait;
  logic       unused_instr;

  load_use_detect #(
    .ZERO_SKIP (ZERO_SKIP)
  ) u_lud (
    .instr_id (instr_id),
    .instr_ex (instr_ex),
    .rfrd_id  (rfrd_id),
    .load_use (load_use)
  );

  assign mem_wait = dm_req && !dm_ack;

`ifdef HAZ_CP0_INTERLOCK_EN
  // An MFC0/ERET must not read CP0 before an older MTC0 has written it
  logic cp0_hazard;
  assign cp0_hazard =
      (is_mfc0(instr_id[31:26], instr_id[25:21]) ||
       is_eret(instr_id[31:26], instr_id[25:21], instr_id[5:0])) &&
      (is_mtc0(instr_ex[31:26], instr_ex[25:21]) ||
       is_mtc0(instr_me[31:26], instr_me[25:21]));
`endif

  assign unused_instr = ^{instr_id, instr_ex, instr_me};

  // State register and load-use bubble counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= HS_RUN;
      lu_cnt <= 2'd0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= cnt_nxt;
    end
  end

  // Next-state and stage-control decode, highest priority first
  always_comb begin
    pc_wr      = 1'b1;
    ifid_wr    = 1'b1;
    idex_wr    = 1'b1;
    exme_wr    = 1'b1;
    mewb_wr    = 1'b1;
    ifid_rst   = 1'b0;
    idex_rst   = 1'b0;
    exme_rst   = 1'b0;
    mewb_rst   = 1'b0;
    pc_sel_exc = PCSEL_SEQ;
    state_nxt  = HS_RUN;
    cnt_nxt    = lu_cnt;

    if (rst) begin
      // Hold the whole pipeline in bubble while reset is asserted
      pc_wr    = 1'b0;
      ifid_wr  = 1'b0;
      idex_wr  = 1'b0;
      exme_wr  = 1'b0;
      mewb_wr  = 1'b0;
      ifid_rst = 1'b1;
      idex_rst = 1'b1;
      exme_rst = 1'b1;
      mewb_rst = 1'b1;
      cnt_nxt  = 2'd0;
    end else if (exc_req) begin
      // Exception wins over everything, aborting any pending stall
      ifid_rst   = 1'b1;
      idex_rst   = 1'b1;
      exme_rst   = 1'b1;
      pc_sel_exc = PCSEL_EXC;
      state_nxt  = HS_FLUSH;
      cnt_nxt    = 2'd0;
    end else if (eret_me) begin
      ifid_rst   = 1'b1;
      idex_rst   = 1'b1;
      exme_rst   = 1'b1;
      pc_sel_exc = PCSEL_EPC;
      state_nxt  = HS_FLUSH;
      cnt_nxt    = 2'd0;
    end else if (state == HS_FLUSH) begin
      // One plain cycle after a flush; no other condition is acted on here
      state_nxt = HS_RUN;
    end else if (mem_wait) begin
      // Freeze everything up to MEM; the counter is left untouched so an
      // interrupted load-use stall resumes where it left off
      pc_wr     = 1'b0;
      ifid_wr   = 1'b0;
      idex_wr   = 1'b0;
      exme_wr   = 1'b0;
      mewb_rst  = 1'b1;
      state_nxt = HS_MEM_WAIT;
    end else if (state == HS_MEM_WAIT) begin
      // Ack cycle: everything advances; load-use is only looked at next cycle
      state_nxt = (lu_cnt != 2'd0) ? HS_LU_STALL : HS_RUN;
    end else if (state == HS_LU_STALL) begin
      pc_wr    = 1'b0;
      ifid_wr  = 1'b0;
      idex_wr  = 1'b0;
      idex_rst = 1'b1;
      if (lu_cnt <= 2'd1) begin
        state_nxt = HS_RUN;
        cnt_nxt   = 2'd0;
      end else begin
        state_nxt = HS_LU_STALL;
        cnt_nxt   = lu_cnt - 2'd1;
      end
    end else if (load_use) begin
      // First bubble is inserted from RUN; extra bubbles come from LU_STALL
      pc_wr     = 1'b0;
      ifid_wr   = 1'b0;
      idex_wr   = 1'b0;
      idex_rst  = 1'b1;
      state_nxt = (LOAD_LAT > 1) ? HS_LU_STALL : HS_RUN;
      cnt_nxt   = LU_EXTRA;
`ifdef HAZ_CP0_INTERLOCK_EN
    end else if (cp0_hazard) begin
      pc_wr     = 1'b0;
      ifid_wr   = 1'b0;
      idex_rst  = 1'b1;
      state_nxt = HS_RUN;
`endif
    end
  end

  assign haz_state = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed testbench for pipe_hazard_ctrl. Two instances share all inputs:
// u1 (LOAD_LAT=1) and u3 (LOAD_LAT=3), both ZERO_SKIP=1. Outputs of each are
// packed as {pc,ifid,idex,exme,mewb _wr, ifid,idex,exme,mewb _rst,
// pc_sel_exc, haz_state}. Inputs change on the falling edge, outputs are
// sampled 1 ns later. Honours HAZ_CP0_INTERLOCK_EN.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  localparam logic [12:0] NORM   = 13'b11111_0000_00_00;
  localparam logic [12:0] LU_R   = 13'b00011_0100_00_00;
  localparam logic [12:0] LU_S   = 13'b00011_0100_00_01;
  localparam logic [12:0] MW_R   = 13'b00001_0001_00_00;
  localparam logic [12:0] MW_W   = 13'b00001_0001_00_10;
  localparam logic [12:0] MW_X   = 13'b11111_0000_00_10;
  localparam logic [12:0] EXC_R  = 13'b11111_1110_01_00;
  localparam logic [12:0] EXC_S  = 13'b11111_1110_01_01;
  localparam logic [12:0] EXC_W  = 13'b11111_1110_01_10;
  localparam logic [12:0] EPC_F  = 13'b11111_1110_10_11;
  localparam logic [12:0] FLSH   = 13'b11111_0000_00_11;
  localparam logic [12:0] RSTV   = 13'b00000_1111_00_00;
  localparam logic [12:0] CP0V   = 13'b00111_0100_00_00;

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] LW5     = {6'b100011, 5'd1, 5'd5, 16'd4};
  localparam logic [31:0] LW0     = {6'b100011, 5'd1, 5'd0, 16'd4};
  localparam logic [31:0] ADD_RS5 = {6'd0, 5'd5, 5'd7, 5'd6, 5'd0, 6'h20};
  localparam logic [31:0] ADD_RT5 = {6'd0, 5'd7, 5'd5, 5'd6, 5'd0, 6'h20};
  localparam logic [31:0] ADD_RS0 = {6'd0, 5'd0, 5'd7, 5'd6, 5'd0, 6'h20};
  localparam logic [31:0] ALU_RT5 = {6'd0, 5'd1, 5'd5, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] MFC0    = {6'b010000, 5'b00000, 5'd8, 5'd12, 11'd0};
  localparam logic [31:0] MTC0    = {6'b010000, 5'b00100, 5'd8, 5'd12, 11'd0};
  localparam logic [31:0] ERET    = {6'b010000, 5'b10000, 15'd0, 6'b011000};

`ifdef HAZ_CP0_INTERLOCK_EN
  localparam logic [12:0] CP0_EXP = CP0V;
`else
  localparam logic [12:0] CP0_EXP = NORM;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr_id, instr_ex, instr_me;
  logic [1:0]  rfrd_id;
  logic        dm_req, dm_ack, exc_req, eret_me;

  logic pc_wr1, ifid_wr1, idex_wr1, exme_wr1, mewb_wr1;
  logic ifid_rst1, idex_rst1, exme_rst1, mewb_rst1;
  logic [1:0] pc_sel1, hs1;
  logic pc_wr3, ifid_wr3, idex_wr3, exme_wr3, mewb_wr3;
  logic ifid_rst3, idex_rst3, exme_rst3, mewb_rst3;
  logic [1:0] pc_sel3, hs3;
  logic [12:0] obs1, obs3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LOAD_LAT(1), .ZERO_SKIP(1'b1)) u1 (
    .clk(clk), .rst(rst), .instr_id(instr_id), .instr_ex(instr_ex),
    .instr_me(instr_me), .rfrd_id(rfrd_id), .dm_req(dm_req), .dm_ack(dm_ack),
    .exc_req(exc_req), .eret_me(eret_me),
    .pc_wr(pc_wr1), .ifid_wr(ifid_wr1), .idex_wr(idex_wr1), .exme_wr(exme_wr1),
    .mewb_wr(mewb_wr1), .ifid_rst(ifid_rst1), .idex_rst(idex_rst1),
    .exme_rst(exme_rst1), .mewb_rst(mewb_rst1), .pc_sel_exc(pc_sel1),
    .haz_state(hs1)
  );

  pipe_hazard_ctrl #(.LOAD_LAT(3), .ZERO_SKIP(1'b1)) u3 (
    .clk(clk), .rst(rst), .instr_id(instr_id), .instr_ex(instr_ex),
    .instr_me(instr_me), .rfrd_id(rfrd_id), .dm_req(dm_req), .dm_ack(dm_ack),
    .exc_req(exc_req), .eret_me(eret_me),
    .pc_wr(pc_wr3), .ifid_wr(ifid_wr3), .idex_wr(idex_wr3), .exme_wr(exme_wr3),
    .mewb_wr(mewb_wr3), .ifid_rst(ifid_rst3), .idex_rst(idex_rst3),
    .exme_rst(exme_rst3), .mewb_rst(mewb_rst3), .pc_sel_exc(pc_sel3),
    .haz_state(hs3)
  );

  assign obs1 = {pc_wr1, ifid_wr1, idex_wr1, exme_wr1, mewb_wr1,
                 ifid_rst1, idex_rst1, exme_rst1, mewb_rst1, pc_sel1, hs1};
  assign obs3 = {pc_wr3, ifid_wr3, idex_wr3, exme_wr3, mewb_wr3,
                 ifid_rst3, idex_rst3, exme_rst3, mewb_rst3, pc_sel3, hs3};

  task automatic set_idle();
    instr_id = NOP;
    instr_ex = NOP;
    instr_me = NOP;
    rfrd_id  = 2'b00;
    dm_req   = 1'b0;
    dm_ack   = 1'b0;
    exc_req  = 1'b0;
    eret_me  = 1'b0;
  endtask

  // Pulse reset for one cycle; returns just after a falling edge in RUN
  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    #1;
    vectors++;
    if (obs1 !== RSTV) begin
      miscompares++;
      $display("[TB] FAIL reset_u1 got %b want %b", obs1, RSTV);
    end
    vectors++;
    if (obs3 !== RSTV) begin
      miscompares++;
      $display("[TB] FAIL reset_u3 got %b want %b", obs3, RSTV);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (obs1 !== NORM) begin
      miscompares++;
      $display("[TB] FAIL post_reset_u1 got %b want %b", obs1, NORM);
    end
    vectors++;
    if (obs3 !== NORM) begin
      miscompares++;
      $display("[TB] FAIL post_reset_u3 got %b want %b", obs3, NORM);
    end
    @(negedge clk);
  endtask

  // LOAD_LAT=1: every cycle is independent, so a table of patterns suffices
  task automatic test_load_use_lat1();
    logic [31:0] ex_t [8];
    logic [31:0] id_t [8];
    logic [1:0]  rf_t [8];
    logic [12:0] ex_v [8];
    ex_t[0] = LW5;     id_t[0] = ADD_RS5; rf_t[0] = 2'b11; ex_v[0] = LU_R;
    ex_t[1] = NOP;     id_t[1] = ADD_RS5; rf_t[1] = 2'b11; ex_v[1] = NORM;
    ex_t[2] = LW5;     id_t[2] = ADD_RT5; rf_t[2] = 2'b10; ex_v[2] = LU_R;
    ex_t[3] = LW5;     id_t[3] = ADD_RT5; rf_t[3] = 2'b01; ex_v[3] = NORM;
    ex_t[4] = LW5;     id_t[4] = ADD_RS5; rf_t[4] = 2'b00; ex_v[4] = NORM;
    ex_t[5] = ALU_RT5; id_t[5] = ADD_RS5; rf_t[5] = 2'b11; ex_v[5] = NORM;
    ex_t[6] = LW0;     id_t[6] = ADD_RS0; rf_t[6] = 2'b11; ex_v[6] = NORM;
    ex_t[7] = LW5;     id_t[7] = ADD_RS5; rf_t[7] = 2'b01; ex_v[7] = LU_R;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      instr_ex = ex_t[i];
      instr_id = id_t[i];
      rfrd_id  = rf_t[i];
      #1;
      vectors++;
      if (obs1 !== ex_v[i]) begin
        miscompares++;
        $display("[TB] FAIL lu1_vec%0d got %b want %b", i, obs1, ex_v[i]);
      end
      @(negedge clk);
    end
    set_idle();
  endtask

  // LOAD_LAT=3: bubble from RUN, then two LU_STALL bubbles, then RUN
  task automatic test_load_use_lat3();
    logic [12:0] exp_t [4];
    exp_t[0] = LU_R;
    exp_t[1] = LU_S;
    exp_t[2] = LU_S;
    exp_t[3] = NORM;
    do_reset();
    instr_ex = LW5;
    instr_id = ADD_RS5;
    rfrd_id  = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (obs3 !== exp_t[i]) begin
        miscompares++;
        $display("[TB] FAIL lu3_cyc%0d got %b want %b", i, obs3, exp_t[i]);
      end
      @(negedge clk);
      instr_ex = NOP;
    end
    do_reset();
    instr_ex = LW0;
    instr_id = ADD_RS0;
    rfrd_id  = 2'b11;
    #1;
    vectors++;
    if (obs3 !== NORM) begin
      miscompares++;
      $display("[TB] FAIL lu3_zero_skip got %b want %b", obs3, NORM);
    end
    @(negedge clk);
    set_idle();
  endtask

  // Four cycles without ack, ack cycle, then a load-use held back until exit
  task automatic test_mem_wait();
    logic [12:0] exp_t [7];
    exp_t[0] = MW_R;
    exp_t[1] = MW_W;
    exp_t[2] = MW_W;
    exp_t[3] = MW_W;
    exp_t[4] = MW_X;
    exp_t[5] = LU_R;
    exp_t[6] = NORM;
    do_reset();
    instr_ex = LW5;
    instr_id = ADD_RS5;
    rfrd_id  = 2'b11;
    for (int i = 0; i < 7; i++) begin
      dm_req   = (i <= 4);
      dm_ack   = (i == 4);
      instr_ex = (i == 6) ? NOP : LW5;
      #1;
      vectors++;
      if (obs1 !== exp_t[i]) begin
        miscompares++;
        $display("[TB] FAIL memwait_cyc%0d got %b want %b", i, obs1, exp_t[i]);
      end
      @(negedge clk);
    end
    set_idle();
  endtask

  task automatic test_exc_in_stall();
    logic [12:0] exp_t [5];
    exp_t[0] = LU_R;
    exp_t[1] = LU_S;
    exp_t[2] = EXC_S;
    exp_t[3] = FLSH;
    exp_t[4] = NORM;
    do_reset();
    instr_id = ADD_RS5;
    rfrd_id  = 2'b11;
    for (int i = 0; i < 5; i++) begin
      instr_ex = (i == 0) ? LW5 : NOP;
      exc_req  = (i == 2);
      #1;
      vectors++;
      if (obs3 !== exp_t[i]) begin
        miscompares++;
        $display("[TB] FAIL exc_stall_cyc%0d got %b want %b", i, obs3, exp_t[i]);
      end
      if (i >= 3) begin
        vectors++;
        if (u3.lu_cnt !== 2'd0) begin
          miscompares++;
          $display("[TB] FAIL exc_stall_cnt%0d got %0d want 0", i, u3.lu_cnt);
        end
      end
      @(negedge clk);
    end
    set_idle();
  endtask

  // exc+eret together, eret re-flushing in FLUSH, and exc aborting MEM_WAIT
  task automatic test_exc_eret();
    logic [12:0] exp_t [7];
    exp_t[0] = EXC_R;
    exp_t[1] = EPC_F;
    exp_t[2] = FLSH;
    exp_t[3] = NORM;
    exp_t[4] = MW_R;
    exp_t[5] = EXC_W;
    exp_t[6] = FLSH;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      exc_req = (i == 0) || (i == 5);
      eret_me = (i == 0) || (i == 1);
      dm_req  = (i == 4) || (i == 5);
      #1;
      vectors++;
      if (obs1 !== exp_t[i]) begin
        miscompares++;
        $display("[TB] FAIL exc_eret_cyc%0d got %b want %b", i, obs1, exp_t[i]);
      end
      @(negedge clk);
    end
    set_idle();
  endtask

  task automatic test_cp0();
    do_reset();
    instr_id = MFC0;
    instr_me = MTC0;
    #1;
    vectors++;
    if (obs1 !== CP0_EXP) begin
      miscompares++;
      $display("[TB] FAIL cp0_mfc0_mtc0me got %b want %b", obs1, CP0_EXP);
    end
    @(negedge clk);
    instr_me = NOP;
    #1;
    vectors++;
    if (obs1 !== NORM) begin
      miscompares++;
      $display("[TB] FAIL cp0_release got %b want %b", obs1, NORM);
    end
    @(negedge clk);
    instr_id = ERET;
    instr_ex = MTC0;
    #1;
    vectors++;
    if (obs1 !== CP0_EXP) begin
      miscompares++;
      $display("[TB] FAIL cp0_eret_mtc0ex got %b want %b", obs1, CP0_EXP);
    end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    dm_req = 1'b1;
    #1;
    vectors++;
    if (obs1 !== MW_R) begin
      miscompares++;
      $display("[TB] FAIL rstwait_enter got %b want %b", obs1, MW_R);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (obs1 !== MW_W) begin
      miscompares++;
      $display("[TB] FAIL rstwait_wait got %b want %b", obs1, MW_W);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (obs1 !== RSTV) begin
      miscompares++;
      $display("[TB] FAIL rstwait_async got %b want %b", obs1, RSTV);
    end
    @(negedge clk);
    set_idle();
    rst = 1'b0;
    #1;
    vectors++;
    if (obs1 !== NORM) begin
      miscompares++;
      $display("[TB] FAIL rstwait_release got %b want %b", obs1, NORM);
    end
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] pipe_hazard_ctrl directed test start");
    test_reset();
    test_load_use_lat1();
    test_load_use_lat3();
    test_mem_wait();
    test_exc_in_stall();
    test_exc_eret();
    test_cp0();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
